// File: rtl/m_ex_issue.sv
// Execute-stage issue register feeding m_alu: operand forwarding, immediate
// extension and ALU selector decode, held in a single valid/ready entry.
module m_ex_issue #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [5:0]       in_funct,
  input  logic             in_alusrc,
  input  logic [WIDTH-1:0] in_rs_val,
  input  logic [WIDTH-1:0] in_rt_val,
  input  logic [15:0]      in_imm,
  input  logic [REGW-1:0]  in_rs_idx,
  input  logic [REGW-1:0]  in_rt_idx,
  input  logic [REGW-1:0]  in_rd_idx,
  input  logic             flush,
  input  logic             exmem_we,
  input  logic [REGW-1:0]  exmem_idx,
  input  logic [WIDTH-1:0] exmem_data,
  input  logic             memwb_we,
  input  logic [REGW-1:0]  memwb_idx,
  input  logic [WIDTH-1:0] memwb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] primerOperando,
  output logic [WIDTH-1:0] segundoOperando,
  output logic [3:0]       selector,
  output logic [REGW-1:0]  out_rd_idx,
  output logic             illegal
);

  logic             capture;
  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;
  logic [WIDTH-1:0] ext_imm;
  logic [3:0]       sel_next;
  logic             ill_next;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready;

  // Register 0 is hard-wired, so a matching index of 0 never forwards.
  always_comb begin
    fwd_rs = in_rs_val;
    if (exmem_we && (exmem_idx != '0) && (exmem_idx == in_rs_idx))
      fwd_rs = exmem_data;
    else if (memwb_we && (memwb_idx != '0) && (memwb_idx == in_rs_idx))
      fwd_rs = memwb_data;
  end

  always_comb begin
    fwd_rt = in_rt_val;
    if (exmem_we && (exmem_idx != '0) && (exmem_idx == in_rt_idx))
      fwd_rt = exmem_data;
    else if (memwb_we && (memwb_idx != '0) && (memwb_idx == in_rt_idx))
      fwd_rt = memwb_data;
  end

  always_comb begin
    if (in_aluop == 2'b11)
      ext_imm = {{(WIDTH-16){1'b0}}, in_imm};
    else
      ext_imm = {{(WIDTH-16){in_imm[15]}}, in_imm};
  end

  always_comb begin
    sel_next = 4'b0010;
    ill_next = 1'b0;
    case (in_aluop)
      2'b00: sel_next = 4'b0010;
      2'b01: sel_next = 4'b0110;
      2'b11: sel_next = 4'b0001;
      default: begin
        case (in_funct)
          6'b100000: sel_next = 4'b0010;
          6'b100010: sel_next = 4'b0110;
          6'b100100: sel_next = 4'b0000;
          6'b100101: sel_next = 4'b0001;
          6'b101010: sel_next = 4'b0111;
          6'b100111: sel_next = 4'b1100;
          default: begin
            sel_next = 4'b1111;
            ill_next = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Flush clears only the valid/illegal flags; data registers keep their value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid       <= 1'b0;
      primerOperando  <= '0;
      segundoOperando <= '0;
      selector        <= '0;
      out_rd_idx      <= '0;
      illegal         <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else if (capture) begin
      out_valid       <= 1'b1;
      primerOperando  <= fwd_rs;
      segundoOperando <= in_alusrc ? ext_imm : fwd_rt;
      selector        <= sel_next;
      out_rd_idx      <= in_rd_idx;
      illegal         <= ill_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_m_ex_issue.sv
// Randomized self-checking bench for m_ex_issue against a behavioural entry model.
module tb_m_ex_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_aluop;
  logic [5:0]  in_funct;
  logic        in_alusrc;
  logic [31:0] in_rs_val, in_rt_val;
  logic [15:0] in_imm;
  logic [4:0]  in_rs_idx, in_rt_idx, in_rd_idx;
  logic        flush;
  logic        exmem_we, memwb_we;
  logic [4:0]  exmem_idx, memwb_idx;
  logic [31:0] exmem_data, memwb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] primerOperando, segundoOperando;
  logic [3:0]  selector;
  logic [4:0]  out_rd_idx;
  logic        illegal;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // reference entry
  logic        m_valid;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_sel;
  logic [4:0]  m_rd;
  logic        m_ill;

  m_ex_issue #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_funct(in_funct), .in_alusrc(in_alusrc),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
    .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_rd_idx(in_rd_idx),
    .flush(flush),
    .exmem_we(exmem_we), .exmem_idx(exmem_idx), .exmem_data(exmem_data),
    .memwb_we(memwb_we), .memwb_idx(memwb_idx), .memwb_data(memwb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .primerOperando(primerOperando), .segundoOperando(segundoOperando),
    .selector(selector), .out_rd_idx(out_rd_idx), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return rf;
    if (exmem_we && exmem_idx == idx) return exmem_data;
    if (memwb_we && memwb_idx == idx) return memwb_data;
    return rf;
  endfunction

  function automatic logic [4:0] alu_code(input logic [1:0] op, input logic [5:0] fn);
    // bit 4 flags an unsupported R-type funct
    case (op)
      2'd0: return 5'h02;
      2'd1: return 5'h06;
      2'd3: return 5'h01;
      default: case (fn)
        6'h20: return 5'h02;
        6'h22: return 5'h06;
        6'h24: return 5'h00;
        6'h25: return 5'h01;
        6'h2A: return 5'h07;
        6'h27: return 5'h0C;
        default: return 5'h1F;
      endcase
    endcase
  endfunction

  task automatic check_outputs(input string pfx);
    check({pfx, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    check({pfx, ".illegal"},   {31'd0, illegal},   {31'd0, m_ill});
    check({pfx, ".primer"},    primerOperando,     m_a);
    check({pfx, ".segundo"},   segundoOperando,    m_b);
    check({pfx, ".selector"},  {28'd0, selector},  {28'd0, m_sel});
    check({pfx, ".rd_idx"},    {27'd0, out_rd_idx}, {27'd0, m_rd});
  endtask

  // Called just after a negedge with inputs already driven; returns after the next negedge.
  task automatic run_cycle(input string pfx);
    logic        rdy;
    logic [31:0] imm_ext;
    logic [4:0]  code;
    logic        nv, nill;
    logic [31:0] na, nb;
    logic [3:0]  nsel;
    logic [4:0]  nrd;
    #1;
    rdy = !flush && (!m_valid || out_ready);
    check({pfx, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    nv = m_valid; nill = m_ill; na = m_a; nb = m_b; nsel = m_sel; nrd = m_rd;
    if (flush) begin
      nv = 1'b0; nill = 1'b0;
    end else if (in_valid && rdy) begin
      if (in_aluop == 2'd3) imm_ext = {16'd0, in_imm};
      else imm_ext = 32'($signed(in_imm));
      code = alu_code(in_aluop, in_funct);
      nv   = 1'b1;
      na   = operand(in_rs_idx, in_rs_val);
      nb   = in_alusrc ? imm_ext : operand(in_rt_idx, in_rt_val);
      nsel = code[3:0];
      nill = code[4];
      nrd  = in_rd_idx;
    end else if (m_valid && out_ready) begin
      nv = 1'b0; nill = 1'b0;
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_ill = nill; m_a = na; m_b = nb; m_sel = nsel; m_rd = nrd;
    check_outputs(pfx);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_aluop = 0; in_funct = 0; in_alusrc = 0;
    in_rs_val = 0; in_rt_val = 0; in_imm = 0;
    in_rs_idx = 0; in_rt_idx = 0; in_rd_idx = 0; flush = 0;
    exmem_we = 0; exmem_idx = 0; exmem_data = 0;
    memwb_we = 0; memwb_idx = 0; memwb_data = 0;
    out_ready = 1;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3 rst = 1;
    #1;
    m_valid = 0; m_ill = 0; m_a = 0; m_b = 0; m_sel = 0; m_rd = 0;
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.selector", {28'd0, selector}, 32'd0);
    check_outputs("rst");
    @(negedge clk);
    rst = 0;
    #1;
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    m_valid = 0; m_ill = 0; m_a = 0; m_b = 0; m_sel = 0; m_rd = 0;
    #12 rst = 0;
    @(negedge clk);
    async_reset();

    // R-type add without hazards
    in_valid = 1; in_aluop = 2'b10; in_funct = 6'h20;
    in_rs_idx = 5'd1; in_rt_idx = 5'd2; in_rd_idx = 5'd9;
    in_rs_val = 32'd5; in_rt_val = 32'd7;
    run_cycle("add");
    check("add.primer5", primerOperando, 32'd5);
    check("add.sel", {28'd0, selector}, 32'h2);

    // forwarding priority
    in_rs_idx = 5'd3;
    exmem_we = 1; exmem_idx = 5'd3; exmem_data = 32'hAA;
    memwb_we = 1; memwb_idx = 5'd3; memwb_data = 32'hBB;
    run_cycle("fwd_ex");
    check("fwd_ex.AA", primerOperando, 32'hAA);
    exmem_idx = 5'd0;
    run_cycle("fwd_wb");
    check("fwd_wb.BB", primerOperando, 32'hBB);
    exmem_we = 0; memwb_we = 0;

    // immediate extension
    in_imm = 16'hFFFF; in_alusrc = 1; in_aluop = 2'b00;
    run_cycle("imm_sx");
    check("imm_sx.val", segundoOperando, 32'hFFFF_FFFF);
    in_aluop = 2'b11;
    run_cycle("imm_zx");
    check("imm_zx.val", segundoOperando, 32'h0000_FFFF);
    check("imm_zx.sel", {28'd0, selector}, 32'h1);

    // stall three cycles, then flush with a pending input
    in_alusrc = 0; in_aluop = 2'b01; in_rs_val = 32'h1234;
    out_ready = 0;
    for (int unsigned i = 0; i < 3; i++) run_cycle("stall");
    flush = 1;
    run_cycle("flush");
    check("flush.valid", {31'd0, out_valid}, 32'd0);
    flush = 0; in_valid = 0; out_ready = 1;
    run_cycle("post_flush");

    // illegal funct then legal op
    in_valid = 1; in_aluop = 2'b10; in_funct = 6'h00;
    run_cycle("ill");
    check("ill.flag", {31'd0, illegal}, 32'd1);
    check("ill.sel", {28'd0, selector}, 32'hF);
    in_funct = 6'h2A;
    run_cycle("ill_clr");
    check("ill_clr.flag", {31'd0, illegal}, 32'd0);

    // randomized traffic
    for (int unsigned c = 0; c < 3000; c++) begin
      automatic logic [5:0] fns [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00, 6'h3F};
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 11) == 0);
      in_aluop   = 2'($urandom);
      in_funct   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
      in_alusrc  = 1'($urandom);
      in_rs_val  = $urandom; in_rt_val = $urandom;
      in_imm     = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      in_rs_idx  = 5'($urandom_range(0, 3));
      in_rt_idx  = 5'($urandom_range(0, 3));
      in_rd_idx  = 5'($urandom);
      exmem_we   = 1'($urandom); exmem_idx = 5'($urandom_range(0, 3)); exmem_data = $urandom;
      memwb_we   = 1'($urandom); memwb_idx = 5'($urandom_range(0, 3)); memwb_data = $urandom;
      if (c == 1500) async_reset();
      run_cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
